// File: rtl/prince_d2_scheduler_pkg.sv
// rtl/prince_d2_scheduler_pkg.sv - shared types and constants for the PRINCE d2 job scheduler
// Holds the scheduler state enum, datapath widths, the LFSR polynomial and its step function.
package prince_sched_pkg;

    localparam int SHARE_W = 64;
    localparam int DATA_W  = 192;
    localparam int DYN_W   = 32;
    localparam int STAT_W  = 216;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } sched_state_e;

    // Galois form: shift right, fold the polynomial in when a one falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/prince_d2_scheduler_if.sv
// rtl/prince_d2_scheduler_if.sv - requester, response and core-side bundle for the scheduler
// Signals: req/req_enc_dec/req_data_0/req_data_1/gnt (requesters), rsp_* (result),
// busy, static_r_in, core_* (to/from the masked PRINCE core).
// Modports: slave = scheduler view, master = environment (requesters, consumer, core).
interface prince_d2_scheduler_if;
    import prince_sched_pkg::*;

    logic [1:0]        req;
    logic [1:0]        req_enc_dec;
    logic [DATA_W-1:0] req_data_0;
    logic [DATA_W-1:0] req_data_1;
    logic [1:0]        gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;
    logic              busy;
    logic [STAT_W-1:0] static_r_in;
    logic              core_start;
    logic [DATA_W-1:0] core_in;
    logic              core_enc_dec;
    logic [DYN_W-1:0]  core_dynamic_r;
    logic [STAT_W-1:0] core_static_r;
    logic [DATA_W-1:0] core_out;
    logic              core_done;

    modport slave (
        input  req, req_enc_dec, req_data_0, req_data_1, rsp_ready, static_r_in, core_out, core_done,
        output gnt, rsp_valid, rsp_id, rsp_data, rsp_timeout, busy,
        output core_start, core_in, core_enc_dec, core_dynamic_r, core_static_r
    );

    modport master (
        output req, req_enc_dec, req_data_0, req_data_1, rsp_ready, static_r_in, core_out, core_done,
        input  gnt, rsp_valid, rsp_id, rsp_data, rsp_timeout, busy,
        input  core_start, core_in, core_enc_dec, core_dynamic_r, core_static_r
    );

endinterface

// File: rtl/prince_d2_scheduler_lfsr.sv
// rtl/prince_d2_scheduler_lfsr.sv - free-running 32-bit Galois LFSR for per-cycle fresh randomness
// Ports: clk, reset (async active-low), state_o (current LFSR state, SEED after reset).
module prince_sched_lfsr
    import prince_sched_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             reset,
    output logic [DYN_W-1:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb state_d = lfsr_next(state_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/prince_d2_scheduler.sv
// rtl/prince_d2_scheduler.sv - two-requester round-robin job controller for the masked PRINCE core
// Ports: clk, reset (async active-low), bus (prince_d2_scheduler_if.slave: requests/grant,
// result handshake, busy, core load/run interface and randomness).
// Macro PRINCE_SCHED_STATIC_REFRESH_EN: core_static_r becomes a register refilled from the
// LFSR during LOAD (load phase stretched to at least 7 cycles); otherwise static_r_in passes through.
module prince_d2_scheduler
    import prince_sched_pkg::*;
#(
    parameter int          LOAD_CYCLES = 2,
    parameter int          TIMEOUT     = 63,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  reset,
    prince_d2_scheduler_if.slave  bus
);

`ifdef PRINCE_SCHED_STATIC_REFRESH_EN
    localparam int L_CYC = (LOAD_CYCLES > 7) ? LOAD_CYCLES : 7;
`else
    localparam int L_CYC = LOAD_CYCLES;
`endif
    localparam logic [5:0] L_LAST  = 6'(L_CYC - 1);
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

    sched_state_e      state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] core_in_q, core_in_d;
    logic              core_enc_dec_q, core_enc_dec_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        gnt;
    logic              win;
    logic [DYN_W-1:0]  lfsr;

    prince_sched_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .state_o (lfsr)
    );

    // ptr_q names the requester served last; the other one wins a tie.
    always_comb begin
        win = 1'b0;
        case (bus.req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~ptr_q;
            default: win = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        core_in_d      = core_in_q;
        core_enc_dec_d = core_enc_dec_q;
        rsp_id_d       = rsp_id_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_timeout_d  = rsp_timeout_q;
        rsp_data_d     = rsp_data_q;
        gnt            = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt            = win ? 2'b10 : 2'b01;
                    ptr_d          = win;
                    rsp_id_d       = win;
                    core_in_d      = win ? bus.req_data_1 : bus.req_data_0;
                    core_enc_dec_d = bus.req_enc_dec[win];
                    cnt_d          = 6'd0;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q == L_LAST) begin
                    cnt_d   = 6'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 6'd1;
                // A done arriving on the last allowed cycle still counts as success.
                if (bus.core_done) begin
                    rsp_data_d    = bus.core_out;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_data_d    = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 6'd0;
            ptr_q          <= 1'b1;
            core_in_q      <= '0;
            core_enc_dec_q <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            rsp_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            core_in_q      <= core_in_d;
            core_enc_dec_q <= core_enc_dec_d;
            rsp_id_q       <= rsp_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_timeout_q  <= rsp_timeout_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

`ifdef PRINCE_SCHED_STATIC_REFRESH_EN
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              unused_static_r_in;

    // Seven 32-bit words fill 216 bits; the oldest word's top bits fall off.
    always_comb begin
        stat_d = stat_q;
        if (state_q == ST_LOAD && cnt_q < 6'd7) begin
            stat_d = {stat_q[STAT_W-DYN_W-1:0], lfsr};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign bus.core_static_r = stat_q;
    assign unused_static_r_in = ^bus.static_r_in;
`else
    assign bus.core_static_r = bus.static_r_in;
`endif

    assign bus.gnt            = gnt;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_id         = rsp_id_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_timeout    = rsp_timeout_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.core_start     = (state_q == ST_LOAD);
    assign bus.core_in        = core_in_q;
    assign bus.core_enc_dec   = core_enc_dec_q;
    assign bus.core_dynamic_r = lfsr;

endmodule
